// File: rtl/seg_mod_counter.sv
// Modulo-MOD up/down counter whose count is stored as a chain of SEG_W-bit
// segments with ripple-enable carry; the full-width modulus compare overrides the carry.
module seg_mod_counter #(
    parameter  int MOD   = 40000,
    parameter  int SEG_W = 16,
    localparam int W     = $clog2(MOD)
) (
    input  logic         clk,
    input  logic         rst_,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic         up,
    output logic [W-1:0] q,
    output logic         tc,
    output logic         wrap,
    output logic         err
);

    localparam int NSEG = (W + SEG_W - 1) / SEG_W;
    localparam logic [W-1:0] MAX_VAL = W'(MOD - 1);

    logic [W-1:0]    cnt_q, cnt_d;
    logic [W-1:0]    cnt_step;
    logic [NSEG-1:0] carry;
    logic            wrap_q, wrap_d;
    logic            err_q, err_d;
    logic            at_max, at_zero;

    assign carry[0] = 1'b1;

    // Each segment steps when every lower segment sits at its roll value
    // for the current direction (all-ones counting up, zero counting down).
    for (genvar gi = 0; gi < NSEG; gi++) begin : g_seg
        localparam int LO = gi * SEG_W;
        localparam int HI = (LO + SEG_W > W) ? W - 1 : LO + SEG_W - 1;
        localparam int SW = HI - LO + 1;

        assign cnt_step[HI:LO] = !carry[gi] ? cnt_q[HI:LO]
                               : up         ? cnt_q[HI:LO] + SW'(1)
                               :              cnt_q[HI:LO] - SW'(1);

        if (gi < NSEG - 1) begin : g_carry
            assign carry[gi+1] = carry[gi] & (up ? (&cnt_q[HI:LO]) : ~(|cnt_q[HI:LO]));
        end
    end

    assign at_max  = (cnt_q == MAX_VAL);
    assign at_zero = (cnt_q == '0);

    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        err_d  = err_q;
        if (clr) begin
            cnt_d = '0;
            err_d = 1'b0;
        end else if (load) begin
            if (load_val > MAX_VAL) begin
                cnt_d = MAX_VAL;
                err_d = 1'b1;
            end else begin
                cnt_d = load_val;
            end
        end else if (en) begin
            // Modulus boundary takes precedence over the segment carry chain.
            if (up && at_max) begin
                cnt_d  = '0;
                wrap_d = 1'b1;
            end else if (!up && at_zero) begin
                cnt_d  = MAX_VAL;
                wrap_d = 1'b1;
            end else begin
                cnt_d = cnt_step;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
            err_q  <= err_d;
        end
    end

    assign q    = cnt_q;
    assign wrap = wrap_q;
    assign err  = err_q;
    assign tc   = en & ~clr & ~load & (up ? at_max : at_zero);

endmodule

// File: tb/tb_seg_mod_counter.sv
// Randomised and directed bench: three counter configurations share control
// inputs and are compared every cycle against an arithmetic modulo model.
module tb_seg_mod_counter;

    localparam int MOD_A = 40000;
    localparam int MOD_B = 100000;
    localparam int MOD_C = 2;

    logic        clk = 1'b0;
    logic        rst_;
    logic        clr, load, en, up;
    logic [15:0] load_val_a, q_a;
    logic [16:0] load_val_b, q_b;
    logic [0:0]  load_val_c, q_c;
    logic        tc_a, tc_b, tc_c;
    logic        wrap_a, wrap_b, wrap_c;
    logic        err_a, err_b, err_c;

    int checks = 0;
    int errors = 0;
    int txn = 0;
    bit verbose = 1'b0;

    int mq [3];
    int merr [3];
    int mwrap [3];

    always #5 clk = ~clk;

    seg_mod_counter #(.MOD(MOD_A), .SEG_W(16)) dut_a (
        .clk(clk), .rst_(rst_), .clr(clr), .load(load), .load_val(load_val_a),
        .en(en), .up(up), .q(q_a), .tc(tc_a), .wrap(wrap_a), .err(err_a));

    seg_mod_counter #(.MOD(MOD_B), .SEG_W(8)) dut_b (
        .clk(clk), .rst_(rst_), .clr(clr), .load(load), .load_val(load_val_b),
        .en(en), .up(up), .q(q_b), .tc(tc_b), .wrap(wrap_b), .err(err_b));

    seg_mod_counter #(.MOD(MOD_C), .SEG_W(2)) dut_c (
        .clk(clk), .rst_(rst_), .clr(clr), .load(load), .load_val(load_val_c),
        .en(en), .up(up), .q(q_c), .tc(tc_c), .wrap(wrap_c), .err(err_c));

    function automatic int mod_of(input int k);
        case (k)
            0:       return MOD_A;
            1:       return MOD_B;
            default: return MOD_C;
        endcase
    endfunction

    function automatic int full_of(input int k);
        case (k)
            0:       return 65535;
            1:       return 131071;
            default: return 1;
        endcase
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s txn=%0d got=%0d expected=%0d", tag, txn, got, exp);
        end
    endtask

    task automatic check_unit(input int k, input int qv, input int wv, input int ev);
        string sfx;
        sfx = (k == 0) ? "_a" : (k == 1) ? "_b" : "_c";
        chk({"q", sfx}, qv, mq[k]);
        chk({"wrap", sfx}, wv, mwrap[k]);
        chk({"err", sfx}, ev, merr[k]);
    endtask

    task automatic check_all();
        check_unit(0, int'(q_a), int'(wrap_a), int'(err_a));
        check_unit(1, int'(q_b), int'(wrap_b), int'(err_b));
        check_unit(2, int'(q_c), int'(wrap_c), int'(err_c));
    endtask

    task automatic reset_model();
        for (int k = 0; k < 3; k++) begin
            mq[k] = 0;
            merr[k] = 0;
            mwrap[k] = 0;
        end
    endtask

    task automatic step(input logic c_i, input logic l_i, input logic e_i, input logic u_i,
                        input int va, input int vb, input int vc);
        int v [3];
        int m;
        int exp_tc;
        clr = c_i; load = l_i; en = e_i; up = u_i;
        load_val_a = va[15:0];
        load_val_b = vb[16:0];
        load_val_c = vc[0:0];
        v[0] = va; v[1] = vb; v[2] = vc;
        #1;
        for (int k = 0; k < 3; k++) begin
            m = mod_of(k);
            exp_tc = (e_i && !c_i && !l_i && (u_i ? (mq[k] == m - 1) : (mq[k] == 0))) ? 1 : 0;
            chk((k == 0) ? "tc_a" : (k == 1) ? "tc_b" : "tc_c",
                (k == 0) ? int'(tc_a) : (k == 1) ? int'(tc_b) : int'(tc_c), exp_tc);
        end
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            m = mod_of(k);
            if (c_i) begin
                mq[k] = 0; merr[k] = 0; mwrap[k] = 0;
            end else if (l_i) begin
                if (v[k] >= m) begin
                    mq[k] = m - 1;
                    merr[k] = 1;
                end else begin
                    mq[k] = v[k];
                end
                mwrap[k] = 0;
            end else if (e_i) begin
                if (u_i) begin
                    mwrap[k] = (mq[k] == m - 1) ? 1 : 0;
                    mq[k] = (mq[k] + 1) % m;
                end else begin
                    mwrap[k] = (mq[k] == 0) ? 1 : 0;
                    mq[k] = (mq[k] + m - 1) % m;
                end
            end else begin
                mwrap[k] = 0;
            end
        end
        #1;
        txn++;
        check_all();
        if (verbose)
            $display("txn %0d clr=%0b load=%0b en=%0b up=%0b | a q=%0d w=%0b e=%0b | b q=%0d w=%0b e=%0b | c q=%0d w=%0b",
                     txn, c_i, l_i, e_i, u_i, q_a, wrap_a, err_a, q_b, wrap_b, err_b, q_c, wrap_c);
    endtask

    function automatic int rand_val(input int k);
        case ($urandom_range(0, 4))
            0:       return mod_of(k) - 1;
            1:       return $urandom_range(0, full_of(k));
            2:       return 0;
            3:       return (full_of(k) >= mod_of(k)) ? mod_of(k) : mod_of(k) - 1;
            default: return $urandom_range(0, mod_of(k) - 1);
        endcase
    endfunction

    initial begin
        rst_ = 1'b0;
        clr = 1'b0; load = 1'b0; en = 1'b1; up = 1'b0;
        load_val_a = '0; load_val_b = '0; load_val_c = '0;
        reset_model();
        #12;
        txn++;
        check_all();
        chk("tc_a_reset_down", int'(tc_a), 1);
        chk("tc_b_reset_down", int'(tc_b), 1);
        en = 1'b0;
        #11;
        rst_ = 1'b1;

        // Free-running count up through one full period of the 40000 counter.
        for (int i = 0; i < MOD_A; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 0);
        $display("txn %0d full-period run done: q_a=%0d wrap_a=%0b q_b=%0d", txn, q_a, wrap_a, q_b);
        chk("q_a_after_period", int'(q_a), 0);
        chk("wrap_a_after_period", int'(wrap_a), 1);

        verbose = 1'b1;
        // Segment carry boundaries in the 8-bit-segment counter.
        step(1'b0, 1'b1, 1'b0, 1'b1, 39999, 255, 1);
        step(1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 100, 65535, 0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 0, 99999, 1);
        step(1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 0);
        // Down-count wrap and borrow across segments.
        step(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 256, 256, 1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0);
        // Out-of-range load, sticky error, clear.
        step(1'b0, 1'b1, 1'b0, 1'b1, 50000, 131071, 1);
        step(1'b0, 1'b1, 1'b0, 1'b1, 5, 5, 0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 0);
        // Priority: clr over load over en; load beats a pending wrap.
        step(1'b1, 1'b1, 1'b1, 1'b1, 7, 7, 1);
        step(1'b0, 1'b1, 1'b0, 1'b1, 39999, 99999, 1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 123, 456, 0);

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
                 rand_val(0), rand_val(1), rand_val(2));
        end

        // Asynchronous reset mid-count, with err set beforehand.
        step(1'b0, 1'b1, 1'b0, 1'b1, 50000, 131071, 1);
        step(1'b0, 1'b1, 1'b0, 1'b1, 12340, 12340, 0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 0);
        chk("q_a_before_reset", int'(q_a), 12345);
        #3;
        rst_ = 1'b0;
        #1;
        reset_model();
        txn++;
        check_all();
        $display("txn %0d async reset: q_a=%0d wrap_a=%0b err_a=%0b", txn, q_a, wrap_a, err_a);
        @(posedge clk);
        #3;
        rst_ = 1'b1;
        step(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 3, 3, 1);
        step(1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_mod_counter.md
SEG_MOD_COUNTER -- requirements
Module: seg_mod_counter

Interface
REQ-001 Parameter MOD, default 40000: counter modulus; count range 0..MOD-1; legal MOD >= 2.
REQ-002 Parameter SEG_W, default 16: internal segment width in bits; legal 2..32.
REQ-003 Derived W = $clog2(MOD) (output width); NSEG = ceil(W/SEG_W) segments.
REQ-004 rst_  input  1  asynchronous active-low reset.
REQ-005 clk  input  1  clock; all state changes on rising edge.
REQ-006 clr  input  1  synchronous clear.
REQ-007 load  input  1  synchronous load strobe.
REQ-008 load_val  input  W  value for load.
REQ-009 en  input  1  count enable.
REQ-010 up  input  1  direction: 1 = increment, 0 = decrement.
REQ-011 q  output  W  current count, registered.
REQ-012 tc  output  1  terminal count, combinational: en & ~clr & ~load & (up ? q==MOD-1 : q==0).
REQ-013 wrap  output  1  registered one-cycle pulse, high the cycle after a wrap.
REQ-014 err  output  1  sticky out-of-range load flag, registered.

Function
REQ-015 Per-edge priority: clr > load > en > hold.
REQ-016 clr: q<=0, err<=0, wrap<=0.
REQ-017 load with load_val < MOD: q<=load_val; err unchanged; wrap<=0.
REQ-018 load with load_val >= MOD: q<=MOD-1, err<=1; wrap<=0.
REQ-019 en & up: q<=q+1 if q<MOD-1; q==MOD-1 -> q<=0 and wrap<=1.
REQ-020 en & ~up: q<=q-1 if q>0; q==0 -> q<=MOD-1 and wrap<=1.
REQ-021 en low (no clr/load): q held; wrap<=0.
REQ-022 wrap high exactly one cycle per wrap event; back-to-back wraps (MOD=2, en held) keep wrap high continuously.
REQ-023 Count stored as NSEG segments of SEG_W bits (top segment W-(NSEG-1)*SEG_W bits); segment k advances only when en and all lower segments are at their roll value for current direction (all-ones up, zero down).
REQ-024 Modulus wrap detected on full q compare and overrides segment carry, so q never holds a value >= MOD.
REQ-025 Direction change takes effect on the same edge as up changes; no extra latency.
REQ-026 Latency: q reflects clr/load/count one cycle after the sampling edge; tc zero-latency; wrap one cycle after the wrapping edge, aligned with the wrapped q.
REQ-027 When MOD is a power of two, behaviour equals a plain W-bit binary up/down counter.
REQ-028 Must synthesise for NSEG=1 and NSEG>1 with identical external behaviour.

Reset
REQ-029 rst_ low, asynchronously: q=0, wrap=0, err=0; tc follows REQ-012 from q=0.
REQ-030 Reset mid-count discards all state; first edge after rst_ release obeys REQ-015 normally.

Verification
REQ-031 MOD=40000, SEG_W=16, en=1, up=1 from reset for 40000 cycles -> q steps 0..39999, returns to 0; tc high at q=39999; wrap high one cycle with q=0.
REQ-032 MOD=100000, SEG_W=8 (W=17, NSEG=3), load 255 then en/up -> q=256; load 65535 then en/up -> 65536; load 99999 then en/up -> 0 and wrap pulse.
REQ-033 MOD=100000, SEG_W=8, load 0, en=1, up=0 -> q=99999, wrap pulse; next edge q=99998; load 256, up=0 -> 255.
REQ-034 MOD=40000, load_val=50000 -> q=39999, err=1; later valid load 5 -> q=5, err stays 1; clr -> q=0, err=0.
REQ-035 Simultaneous clr=1, load=1, en=1 -> q=0; load=1 with en=1 at q=39999 -> q=load_val, no wrap, tc=0.
REQ-036 rst_ asserted mid-count at q=12345 between edges -> q=0, wrap=0, err=0 immediately, no clock needed.
